pipe_hold_ctrl: RTL and testbench

Pipeline hold/flush controller that drives the hold_flag bus consumed by the pc, if_id and id_ex pipeline registers. It also drives the PC redirect (jump flag/address).
- Merges hold and redirect requests from EX (jump, multi-cycle op), the bus arbiter and the interrupt controller into one prioritised hold level.
- Sequences multi-cycle post-redirect bubbles and the interrupt-entry handshake.

---
 rtl/pipe_hold_ctrl_if.sv | 25 ++
 rtl/pipe_hold_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hold_ctrl_if.sv
// Request/redirect signal bundle between the pipeline sources and pipe_hold_ctrl.
// The master side (EX, bus arbiter, interrupt controller) drives the _i requests.
interface pipe_hold_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic        int_ack_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic        stall_err_o;

  modport master (
    output jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, int_req_i, int_addr_i,
    input  int_ack_o, jump_flag_o, jump_addr_o, hold_flag_o, stall_err_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, int_req_i, int_addr_i,
    output int_ack_o, jump_flag_o, jump_addr_o, hold_flag_o, stall_err_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: prioritised hold level, PC redirect, interrupt entry.
// Optional stall watchdog on hold_ex_i is enabled by defining STALL_WATCHDOG_EN.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_LIMIT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hold_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_INT   = 2'd2;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);
  localparam bit         FLUSH_EN  = (FLUSH_CYCLES != 0);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] int_vec_q, int_vec_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    int_vec_d = int_vec_q;
    case (state_q)
      ST_RUN: begin
        if (bus.jump_flag_i && FLUSH_EN) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_CNT;
        end else if (bus.int_req_i && !bus.jump_flag_i && !bus.hold_ex_i && !bus.hold_bus_i) begin
          state_d   = ST_INT;
          int_vec_d = bus.int_addr_i;
        end
      end
      ST_FLUSH: begin
        if (bus.jump_flag_i) begin
          cnt_d = FLUSH_CNT;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_INT: begin
        if (FLUSH_EN) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_CNT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      int_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      int_vec_q <= int_vec_d;
    end
  end

  // Mealy outputs; forced low while reset is held so no redirect leaks out.
  always_comb begin
    bus.int_ack_o   = 1'b0;
    bus.jump_flag_o = 1'b0;
    bus.jump_addr_o = '0;
    bus.hold_flag_o = HOLD_NONE;
    if (rst) begin
      if (state_q == ST_INT) begin
        bus.int_ack_o   = 1'b1;
        bus.jump_flag_o = 1'b1;
        bus.jump_addr_o = int_vec_q;
      end else if (bus.jump_flag_i) begin
        bus.jump_flag_o = 1'b1;
        bus.jump_addr_o = bus.jump_addr_i;
      end
      if (bus.jump_flag_i || bus.hold_ex_i || state_q == ST_FLUSH || state_q == ST_INT)
        bus.hold_flag_o = HOLD_ID;
      else if (bus.hold_bus_i)
        bus.hold_flag_o = HOLD_PC;
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam int unsigned    WDW    = $clog2(STALL_LIMIT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(STALL_LIMIT);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           stall_err_q, stall_err_d;

  always_comb begin
    wd_cnt_d = '0;
    if (bus.hold_ex_i)
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 1'b1;
    stall_err_d = stall_err_q | (bus.hold_ex_i && wd_cnt_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign bus.stall_err_o = stall_err_q;
`else
  logic [31:0] unused_stall_limit;
  assign unused_stall_limit = 32'(STALL_LIMIT);
  assign bus.stall_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl with FLUSH_CYCLES=2, STALL_LIMIT=4.
// Expected output vectors are queued when a cycle is driven and compared mid-cycle.
module tb_pipe_hold_ctrl;

`ifdef STALL_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        jf;
    logic [31:0] ja;
    logic        hex;
    logic        hbus;
    logic        ireq;
    logic [31:0] iaddr;
    logic [37:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [37:0] sb[$];

  pipe_hold_ctrl_if bus_if ();

  pipe_hold_ctrl #(.FLUSH_CYCLES(2), .STALL_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Packed as {int_ack, jump_flag, jump_addr[31:0], hold_flag[2:0], stall_err}
  function automatic logic [37:0] e(input logic ack, input logic jf, input logic [31:0] ja,
                                    input logic [2:0] hold, input logic err);
    return {ack, jf, ja, hold, err};
  endfunction

  function automatic row_t mk(input logic r, input logic jf, input logic [31:0] ja,
                              input logic hex, input logic hbus, input logic ireq,
                              input logic [31:0] iaddr, input logic [37:0] exp);
    row_t x;
    x.rst = r; x.jf = jf; x.ja = ja; x.hex = hex; x.hbus = hbus;
    x.ireq = ireq; x.iaddr = iaddr; x.exp = exp;
    return x;
  endfunction

  function automatic logic [37:0] obs();
    return {bus_if.int_ack_o, bus_if.jump_flag_o, bus_if.jump_addr_o,
            bus_if.hold_flag_o, bus_if.stall_err_o};
  endfunction

  task automatic drive(input row_t r);
    @(posedge clk);
    #1;
    rst                = r.rst;
    bus_if.jump_flag_i = r.jf;
    bus_if.jump_addr_i = r.ja;
    bus_if.hold_ex_i   = r.hex;
    bus_if.hold_bus_i  = r.hbus;
    bus_if.int_req_i   = r.ireq;
    bus_if.int_addr_i  = r.iaddr;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(0, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'hFFFF_FFFF, e(0, 0, 0, 0, 0)),
             mk(0, 1, 32'h0000_0100, 1, 1, 1, 32'h0000_0040, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_jump();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 1, 32'h0000_0100, 0, 0, 0, 0, e(0, 1, 32'h100, 3, 0)),
             mk(1, 0, 32'h0000_0100, 0, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL jump[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 0, 0, 0, 1, 0, 0, e(0, 0, 0, 1, 0)),
             mk(1, 0, 0, 1, 1, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL priority[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_interrupt();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 0, 0, 0, 1, 1, 32'h0000_0040, e(0, 0, 0, 1, 0)),
             mk(1, 0, 0, 0, 1, 1, 32'h0000_0040, e(0, 0, 0, 1, 0)),
             mk(1, 0, 0, 0, 1, 1, 32'h0000_0040, e(0, 0, 0, 1, 0)),
             mk(1, 0, 0, 0, 0, 1, 32'h0000_0040, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 1, 32'h0000_0000, e(1, 1, 32'h40, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL interrupt[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_jump_in_flush();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 1, 32'h0000_0100, 0, 0, 0, 0, e(0, 1, 32'h100, 3, 0)),
             mk(1, 1, 32'h0000_0200, 0, 0, 1, 32'h40, e(0, 1, 32'h200, 3, 0)),
             mk(1, 0, 0, 0, 0, 1, 32'h40, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL jump_in_flush[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 1, 32'h0000_0300, 1, 1, 0, 0, e(0, 1, 32'h300, 3, 0)),
             mk(1, 0, 0, 1, 1, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 1, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 1, 0, 0, e(0, 0, 0, 1, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_reset_midway();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 1, 32'h0000_0100, 0, 0, 0, 0, e(0, 1, 32'h100, 3, 0)),
             mk(0, 1, 32'h0000_0100, 1, 0, 0, 0, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 1, 32'h0000_0080, e(0, 0, 0, 0, 0)),
             mk(0, 0, 0, 0, 0, 1, 32'h0000_0080, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL reset_midway[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  task automatic test_watchdog();
    row_t rows[$];
    logic [37:0] ex, ac;
    rows = '{mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 1, 0, 0, 0, e(0, 0, 0, 3, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, WD)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, WD)),
             mk(0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)),
             mk(1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0))};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      ex = sb.pop_front(); ac = obs(); n_chk++;
      if (ac !== ex) begin
        n_fail++;
        $display("FAIL watchdog[%0d]: got %h expected %h", i, ac, ex);
      end
    end
  endtask

  initial begin
    bus_if.jump_flag_i = 1'b0;
    bus_if.jump_addr_i = '0;
    bus_if.hold_ex_i   = 1'b0;
    bus_if.hold_bus_i  = 1'b0;
    bus_if.int_req_i   = 1'b0;
    bus_if.int_addr_i  = '0;
    test_reset();
    test_jump();
    test_priority();
    test_interrupt();
    test_jump_in_flush();
    test_back_to_back();
    test_reset_midway();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
